// File: rtl/fixed_pkg.sv
// Shared types and default geometry for the integer-to-fixed block loader.
package fixed_pkg;

  typedef enum logic [1:0] {
    FILL,
    CONV,
    HOLD
  } loader_state_t;

  localparam int unsigned DEF_INT_BITS     = 16;
  localparam int unsigned DEF_FRAC_BITS    = 16;
  localparam int unsigned DEF_INPUT_BITS   = 8;
  localparam int unsigned DEF_NUM_INTEGERS = 64;

  localparam int unsigned W     = DEF_INT_BITS + DEF_FRAC_BITS;
  localparam int unsigned IDX_W = $clog2(DEF_NUM_INTEGERS);

  // Index width that stays legal for a single-element block.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/multi_integer_to_fixed.sv
// Converts a packed vector of unsigned samples to unsigned fixed point (value = sample * 2^FRAC_BITS).
module multi_integer_to_fixed #(
  parameter int unsigned INT_BITS     = 16,
  parameter int unsigned FRAC_BITS    = 16,
  parameter int unsigned INPUT_BITS   = 8,
  parameter int unsigned NUM_INTEGERS = 64
) (
  input  logic [NUM_INTEGERS*INPUT_BITS-1:0]           samples_i,
  output logic [NUM_INTEGERS*(INT_BITS+FRAC_BITS)-1:0] fixed_o
);

  localparam int unsigned ELEM_W = INT_BITS + FRAC_BITS;

  // Upper integer bits and all fraction bits stay zero; the sample lands just above the fraction.
  always_comb begin
    fixed_o = '0;
    for (int unsigned k = 0; k < NUM_INTEGERS; k++) begin
      fixed_o[k*ELEM_W + FRAC_BITS +: INPUT_BITS] = samples_i[k*INPUT_BITS +: INPUT_BITS];
    end
  end

endmodule

// File: rtl/int_block_fixed_loader.sv
// Collects NUM_INTEGERS samples, converts the block to fixed point in one step and
// presents it under a valid/ready handshake.
module int_block_fixed_loader
  import fixed_pkg::*;
#(
  parameter int unsigned INT_BITS     = DEF_INT_BITS,
  parameter int unsigned FRAC_BITS    = DEF_FRAC_BITS,
  parameter int unsigned INPUT_BITS   = DEF_INPUT_BITS,
  parameter int unsigned NUM_INTEGERS = DEF_NUM_INTEGERS
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          flush,
  input  logic                                          in_valid,
  output logic                                          in_ready,
  input  logic [INPUT_BITS-1:0]                         in_data,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic [NUM_INTEGERS*(INT_BITS+FRAC_BITS)-1:0]  out_block,
  output logic [15:0]                                   block_cnt
);

  localparam int unsigned ELEM_W = INT_BITS + FRAC_BITS;
  localparam int unsigned IX_W   = idx_width(NUM_INTEGERS);
  localparam logic [IX_W-1:0] LAST_IDX = IX_W'(NUM_INTEGERS - 1);

  if (INT_BITS < INPUT_BITS) begin : g_width_check
    $error("int_block_fixed_loader: INT_BITS must be >= INPUT_BITS");
  end

  loader_state_t                    state_q, state_d;
  logic [IX_W-1:0]                  idx_q, idx_d;
  logic [INPUT_BITS-1:0]            sample_q [NUM_INTEGERS];
  logic [NUM_INTEGERS*INPUT_BITS-1:0] samples_packed;
  logic [NUM_INTEGERS*ELEM_W-1:0]   fixed_w;
  logic [NUM_INTEGERS*ELEM_W-1:0]   out_block_q;
  logic [15:0]                      block_cnt_q;
  logic                             wr_en, cap_en, cnt_inc;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wr_en   = 1'b0;
    cap_en  = 1'b0;
    cnt_inc = 1'b0;
    unique case (state_q)
      FILL: begin
        if (flush) begin
          idx_d = '0;
        end else if (in_valid) begin
          wr_en = 1'b1;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = CONV;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      CONV: begin
        // A flush here abandons the block before it is ever captured.
        if (flush) begin
          idx_d   = '0;
          state_d = FILL;
        end else begin
          cap_en  = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          cnt_inc = 1'b1;
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FILL;
      idx_q       <= '0;
      out_block_q <= '0;
      block_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (cap_en)  out_block_q <= fixed_w;
      if (cnt_inc) block_cnt_q <= block_cnt_q + 16'd1;
    end
  end

  // Sample storage carries no reset; stale contents are overwritten before each capture.
  always_ff @(posedge clk) begin
    if (wr_en) sample_q[idx_q] <= in_data;
  end

  always_comb begin
    samples_packed = '0;
    for (int unsigned k = 0; k < NUM_INTEGERS; k++) begin
      samples_packed[k*INPUT_BITS +: INPUT_BITS] = sample_q[k];
    end
  end

  multi_integer_to_fixed #(
    .INT_BITS     (INT_BITS),
    .FRAC_BITS    (FRAC_BITS),
    .INPUT_BITS   (INPUT_BITS),
    .NUM_INTEGERS (NUM_INTEGERS)
  ) u_conv (
    .samples_i (samples_packed),
    .fixed_o   (fixed_w)
  );

  assign in_ready  = (state_q == FILL);
  assign out_valid = (state_q == HOLD);
  assign out_block = out_block_q;
  assign block_cnt = block_cnt_q;

endmodule

// File: tb/tb_int_block_fixed_loader.sv
// Scoreboard bench for int_block_fixed_loader: driver feeds a sample-level model, monitor checks delivered blocks.
module tb_int_block_fixed_loader;

  localparam int NI = 64;
  localparam int W  = 32;

  typedef logic [W-1:0] blk_t [NI];

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                flush = 1'b0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [7:0]          in_data = '0;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic [NI*W-1:0]     out_block;
  logic [15:0]         block_cnt;

  blk_t        exp_q[$];
  int unsigned acc[$];
  bit          pending = 1'b0;
  int          since_full = 0;
  int          exp_cnt = 0;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  int_block_fixed_loader #(
    .INT_BITS     (16),
    .FRAC_BITS    (16),
    .INPUT_BITS   (8),
    .NUM_INTEGERS (NI)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_block (out_block),
    .block_cnt (block_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, expv);
    end
  endtask

  // Monitor: every presented block must equal the oldest expected block.
  initial begin
    int bad;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_block actual=valid required=none_pending");
        end else begin
          bad = -1;
          for (int k = 0; k < NI; k++)
            if (bad < 0 && out_block[k*W +: W] !== exp_q[0][k]) bad = k;
          checks++;
          if (bad >= 0) begin
            failures++;
            $display("FAIL block_elem[%0d] actual=%0h required=%0h",
                     bad, out_block[bad*W +: W], exp_q[0][bad]);
          end
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  // One clock of stimulus; model expectations are derived from the sample/block rules.
  task automatic cycle(input bit v, input logic [7:0] d, input bit ordy, input bit fl);
    bit exp_ov, acc_now, hs;
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    @(negedge clk);
    exp_ov = pending && (since_full >= 1);
    chk("in_ready",  64'(in_ready),  64'(!pending));
    chk("out_valid", 64'(out_valid), 64'(exp_ov));
    chk("block_cnt", 64'(block_cnt), 64'(16'(exp_cnt)));
    acc_now = v && !pending && !fl;
    hs      = exp_ov && ordy;
    @(posedge clk);
    #1;
    if (fl && !pending) begin
      acc.delete();
    end else if (fl && pending && !exp_ov) begin
      void'(exp_q.pop_back());
      pending = 1'b0;
      acc.delete();
    end else if (pending) begin
      if (hs) begin
        pending = 1'b0;
        exp_cnt++;
      end else begin
        since_full++;
      end
    end
    if (acc_now) begin
      acc.push_back(int'(d));
      if (acc.size() == NI) begin
        blk_t b;
        for (int k = 0; k < NI; k++) b[k] = W'(acc[k] * 65536);
        exp_q.push_back(b);
        acc.delete();
        pending    = 1'b1;
        since_full = 0;
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (pending && n < 20) begin
      cycle(1'b0, 8'($urandom), 1'b1, 1'b0);
      n++;
    end
    chk("drained_queue", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic run_random(input int nblk);
    int n, start;
    n = 0;
    start = exp_cnt;
    while (exp_cnt < start + nblk && n < 3000) begin
      cycle(($urandom % 100) < 60, 8'($urandom), ($urandom % 100) < 50, 1'b0);
      n++;
    end
    chk("rand_block_cnt", 64'(block_cnt), 64'(16'(start + nblk)));
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_in_ready",  64'(in_ready),   64'd1);
    chk("rst_out_valid", 64'(out_valid),  64'd0);
    chk("rst_block_cnt", 64'(block_cnt),  64'd0);
    chk("rst_out_block", 64'(|out_block), 64'd0);
    acc.delete();
    exp_q.delete();
    pending    = 1'b0;
    since_full = 0;
    exp_cnt    = 0;
    in_valid   = 1'b0;
    flush      = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready",  64'(in_ready),   64'd1);
    chk("reset_out_valid", 64'(out_valid),  64'd0);
    chk("reset_block_cnt", 64'(block_cnt),  64'd0);
    chk("reset_out_block", 64'(|out_block), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Ramp 0..63, consumer always ready.
    for (int i = 0; i < NI; i++) cycle(1'b1, 8'(i), 1'b1, 1'b0);
    drain();
    chk("ramp_block_cnt", 64'(block_cnt), 64'd1);

    // All 0xFF with consumer stalled; extra valid-only inputs must be refused.
    for (int i = 0; i < NI; i++) cycle(1'b1, 8'hFF, 1'b0, 1'b0);
    repeat (20) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
    drain();

    // Random gaps and back-pressure over three blocks.
    run_random(3);
    drain();

    // Flush mid-fill with a coincident valid sample.
    for (int i = 0; i < 30; i++) cycle(1'b1, 8'($urandom), 1'b1, 1'b0);
    cycle(1'b1, 8'hAA, 1'b1, 1'b1);
    for (int i = 0; i < NI; i++) cycle(1'b1, 8'(100 + i), 1'b1, 1'b0);
    drain();

    // Flush while holding a block must not withdraw it.
    for (int i = 0; i < NI; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
    repeat (3) cycle(1'b0, 8'h00, 1'b0, 1'b0);
    cycle(1'b1, 8'h11, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    drain();

    // Reset mid-block, then a full block.
    for (int i = 0; i < 40; i++) cycle(1'b1, 8'($urandom), 1'b1, 1'b0);
    do_reset();
    for (int i = 0; i < NI; i++) cycle(1'b1, 8'($urandom), 1'b1, 1'b0);
    drain();
    chk("cnt_after_reset", 64'(block_cnt), 64'd1);

    // Reset while holding a block.
    for (int i = 0; i < NI; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
    repeat (3) cycle(1'b0, 8'h00, 1'b0, 1'b0);
    do_reset();
    run_random(1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
